// File: rtl/bypass_forward_ctrl.sv
// Operand forwarding and load-use interlock at the ID/EX boundary.
// Picks the youngest valid producer per source port and stalls ID on a load-use hazard.
module bypass_forward_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0]   id_rf_data,
  input  logic                        ex_wr_en,
  input  logic                        ex_is_load,
  input  logic [ADDR_W-1:0]           ex_wr_addr,
  input  logic [DATA_W-1:0]           ex_alu_res,
  input  logic                        mem_wr_en,
  input  logic [ADDR_W-1:0]           mem_wr_addr,
  input  logic [DATA_W-1:0]           mem_wr_data,
  input  logic                        wb_wr_en,
  input  logic [ADDR_W-1:0]           wb_wr_addr,
  input  logic [DATA_W-1:0]           wb_wr_data,
  input  logic                        flush,
  output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
  output logic [NUM_SRC*4-1:0]        fwd_sel,
  output logic                        stall,
  output logic [CNT_W-1:0]            stat_stall_cyc,
  output logic [CNT_W-1:0]            stat_fwd_evt
);

  localparam int PC_W  = $clog2(NUM_SRC + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [1:0] HOLD_INIT = 2'(LOAD_LAT - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         cnt_reg, cnt_next;
  logic [CNT_W-1:0]   stall_cyc_reg, stall_cyc_next;
  logic [CNT_W-1:0]   fwd_evt_reg, fwd_evt_next;
  logic [NUM_SRC-1:0] ld_match;
  logic [NUM_SRC-1:0] fwd_port;
  logic [PC_W-1:0]    fwd_cnt;
  logic [PC_W-1:0]    fwd_add;
  logic [SUM_W-1:0]   stall_sum, fwd_sum;
  logic               hazard;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_port
      logic [ADDR_W-1:0] src;
      logic              src_live;
      logic              m_ex, m_mem, m_wb;
      logic [3:0]        sel;
      logic [DATA_W-1:0] data;

      assign src      = id_src_addr[gi*ADDR_W +: ADDR_W];
      assign src_live = id_src_used[gi] && (src != '0);
      assign m_ex     = src_live && ex_wr_en  && (ex_wr_addr  == src);
      assign m_mem    = src_live && mem_wr_en && (mem_wr_addr == src);
      assign m_wb     = src_live && wb_wr_en  && (wb_wr_addr  == src);

      // A load in EX has no data yet, so it is skipped and older stages are considered.
      always_comb begin
        sel  = 4'b0001;
        data = id_rf_data[gi*DATA_W +: DATA_W];
        if (m_ex && !ex_is_load) begin
          sel  = 4'b0010;
          data = ex_alu_res;
        end else if (m_mem) begin
          sel  = 4'b0100;
          data = mem_wr_data;
        end else if (m_wb) begin
          sel  = 4'b1000;
          data = wb_wr_data;
        end
      end

      assign fwd_sel[gi*4 +: 4]          = sel;
      assign fwd_data[gi*DATA_W +: DATA_W] = data;
      assign ld_match[gi]                = m_ex && ex_is_load;
      assign fwd_port[gi]                = !sel[0];
    end
  endgenerate

  assign hazard = id_valid && !flush && (|ld_match);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      stall_cyc_reg <= '0;
      fwd_evt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      stall_cyc_reg <= stall_cyc_next;
      fwd_evt_reg   <= fwd_evt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state_next = HOLD;
            cnt_next   = HOLD_INIT;
          end
        end
        HOLD: begin
          cnt_next = cnt_reg - 2'd1;
          if (cnt_reg == 2'd1) state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    case (state_reg)
      IDLE: stall = hazard;
      HOLD: stall = !flush;
    endcase
  end

  always_comb begin
    fwd_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) fwd_cnt = fwd_cnt + PC_W'(fwd_port[i]);
  end

  // The extra sum bit flags overflow so the counters stick at all-ones.
  assign fwd_add        = (id_valid && !stall) ? fwd_cnt : '0;
  assign stall_sum      = {1'b0, stall_cyc_reg} + SUM_W'(stall);
  assign fwd_sum        = {1'b0, fwd_evt_reg} + SUM_W'(fwd_add);
  assign stall_cyc_next = stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
  assign fwd_evt_next   = fwd_sum[CNT_W]   ? '1 : fwd_sum[CNT_W-1:0];

  assign stat_stall_cyc = stall_cyc_reg;
  assign stat_fwd_evt   = fwd_evt_reg;

endmodule

// File: tb/tb_bypass_forward_ctrl.sv
// Directed checks of forwarding priority, load-use stall length, flush/reset and counter saturation.
// Three instances share stimulus: LOAD_LAT=1, LOAD_LAT=3 and a 4-bit-counter variant.
module tb_bypass_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic [63:0] id_rf_data;
  logic        ex_wr_en, ex_is_load;
  logic [4:0]  ex_wr_addr;
  logic [31:0] ex_alu_res;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        wb_wr_en;
  logic [4:0]  wb_wr_addr;
  logic [31:0] wb_wr_data;
  logic        flush;

  logic [63:0] fwd_data1, fwd_data3, fwd_data_s;
  logic [7:0]  fwd_sel1, fwd_sel3, fwd_sel_s;
  logic        stall1, stall3, stall_s;
  logic [31:0] stat_stall1, stat_fwd1, stat_stall3, stat_fwd3;
  logic [3:0]  stat_stall_s, stat_fwd_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bypass_forward_ctrl #(.LOAD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_rf_data(id_rf_data), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_alu_res(ex_alu_res),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .flush(flush), .fwd_data(fwd_data1), .fwd_sel(fwd_sel1), .stall(stall1),
    .stat_stall_cyc(stat_stall1), .stat_fwd_evt(stat_fwd1));

  bypass_forward_ctrl #(.LOAD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_rf_data(id_rf_data), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_alu_res(ex_alu_res),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .flush(flush), .fwd_data(fwd_data3), .fwd_sel(fwd_sel3), .stall(stall3),
    .stat_stall_cyc(stat_stall3), .stat_fwd_evt(stat_fwd3));

  bypass_forward_ctrl #(.LOAD_LAT(1), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_rf_data(id_rf_data), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_alu_res(ex_alu_res),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .flush(flush), .fwd_data(fwd_data_s), .fwd_sel(fwd_sel_s), .stall(stall_s),
    .stat_stall_cyc(stat_stall_s), .stat_fwd_evt(stat_fwd_s));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    id_valid    = 1'b0;
    id_src_addr = '0;
    id_src_used = '0;
    id_rf_data  = {32'h0000_BBBB, 32'h0000_AAAA};
    ex_wr_en    = 1'b0;
    ex_is_load  = 1'b0;
    ex_wr_addr  = '0;
    ex_alu_res  = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    wb_wr_en    = 1'b0;
    wb_wr_addr  = '0;
    wb_wr_data  = '0;
    flush       = 1'b0;
  endtask

  task automatic load_use_r7();
    clr_inputs();
    id_valid    = 1'b1;
    id_src_addr = {5'd7, 5'd0};
    id_src_used = 2'b10;
    ex_wr_en    = 1'b1;
    ex_is_load  = 1'b1;
    ex_wr_addr  = 5'd7;
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    tick();
    tick();
    @(negedge clk);
    check_eq("rst_stall", {61'd0, stall1, stall3, stall_s}, 64'd0);
    check_eq("rst_cnt1", {stat_stall1, stat_fwd1}, 64'd0);
    check_eq("rst_cnt3", {stat_stall3, stat_fwd3}, 64'd0);

    // Priority: EX > MEM > WB for r5 on port 0; port 1 unused selects RF.
    tick();
    rst = 1'b0;
    id_valid    = 1'b1;
    id_src_addr = {5'd9, 5'd5};
    id_src_used = 2'b01;
    ex_wr_en  = 1'b1; ex_wr_addr  = 5'd5; ex_alu_res  = 32'h11;
    mem_wr_en = 1'b1; mem_wr_addr = 5'd5; mem_wr_data = 32'h22;
    wb_wr_en  = 1'b1; wb_wr_addr  = 5'd5; wb_wr_data  = 32'h33;
    @(negedge clk);
    check_eq("prio_ex_sel", fwd_sel1, 64'h12);
    check_eq("prio_ex_data", fwd_data1[31:0], 64'h11);
    check_eq("unused_p1_data", fwd_data1[63:32], 64'hBBBB);
    check_eq("cnt_first_cycle", stat_fwd1, 64'd0);

    tick();
    ex_wr_en = 1'b0;
    @(negedge clk);
    check_eq("prio_mem_sel", fwd_sel1[3:0], 64'b0100);
    check_eq("prio_mem_data", fwd_data1[31:0], 64'h22);

    tick();
    mem_wr_en = 1'b0;
    @(negedge clk);
    check_eq("prio_wb_sel", fwd_sel1[3:0], 64'b1000);
    check_eq("prio_wb_data", fwd_data1[31:0], 64'h33);

    // Register 0 never forwards.
    tick();
    clr_inputs();
    id_valid    = 1'b1;
    id_src_used = 2'b01;
    ex_wr_en    = 1'b1;
    ex_alu_res  = 32'hDEAD;
    @(negedge clk);
    check_eq("r0_sel", fwd_sel1[3:0], 64'b0001);
    check_eq("r0_data", fwd_data1[31:0], 64'hAAAA);
    check_eq("fwd_evt_after3", stat_fwd1, 64'd3);
    tick();
    clr_inputs();
    @(negedge clk);
    check_eq("fwd_evt_r0_unchanged", stat_fwd1, 64'd3);

    // Load-use on r7 via port 1.
    tick();
    load_use_r7();
    @(negedge clk);
    check_eq("lu_stall_c1", {62'd0, stall1, stall3}, 64'b11);
    check_eq("lu_load_no_fwd", fwd_sel1[7:4], 64'b0001);

    tick();
    clr_inputs();
    id_valid    = 1'b1;
    id_src_addr = {5'd7, 5'd0};
    id_src_used = 2'b10;
    mem_wr_en   = 1'b1; mem_wr_addr = 5'd7; mem_wr_data = 32'hCAFE;
    @(negedge clk);
    check_eq("ll1_stall_c2", stall1, 64'd0);
    check_eq("ll1_mem_sel", fwd_sel1[7:4], 64'b0100);
    check_eq("ll1_mem_data", fwd_data1[63:32], 64'hCAFE);
    check_eq("ll1_stall_cnt", stat_stall1, 64'd1);
    check_eq("ll3_stall_c2", stall3, 64'd1);

    tick();
    clr_inputs();
    @(negedge clk);
    check_eq("ll3_stall_c3", stall3, 64'd1);
    check_eq("ll1_stall_c3", stall1, 64'd0);

    tick();
    @(negedge clk);
    check_eq("ll3_stall_c4", stall3, 64'd0);
    check_eq("ll3_stall_cnt", stat_stall3, 64'd3);

    // Flush in the second stall cycle, hazard inputs still present.
    tick();
    load_use_r7();
    @(negedge clk);
    check_eq("fl_stall_c1", stall3, 64'd1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    check_eq("fl_stall_c2", {62'd0, stall1, stall3}, 64'b00);
    tick();
    clr_inputs();
    @(negedge clk);
    check_eq("fl_idle_next", stall3, 64'd0);
    check_eq("fl_stall_cnt", stat_stall3, 64'd4);

    // Reset mid-HOLD: stall stays up during the reset cycle, cleared after.
    tick();
    load_use_r7();
    @(negedge clk);
    check_eq("rs_stall_c1", stall3, 64'd1);
    tick();
    clr_inputs();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rs_stall_c2", stall3, 64'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rs_stall_after", stall3, 64'd0);
    check_eq("rs_cnt3", {stat_stall3, stat_fwd3}, 64'd0);

    // Both ports forward every cycle: 4-bit counter must stick at 15.
    for (int k = 1; k <= 20; k++) begin
      tick();
      clr_inputs();
      id_valid    = 1'b1;
      id_src_addr = {5'd4, 5'd3};
      id_src_used = 2'b11;
      ex_wr_en  = 1'b1; ex_wr_addr  = 5'd3; ex_alu_res  = 32'h1234;
      mem_wr_en = 1'b1; mem_wr_addr = 5'd4; mem_wr_data = 32'h5678;
      @(negedge clk);
      if (k == 1) begin
        check_eq("both_sel", fwd_sel1, 64'h42);
        check_eq("both_data", fwd_data1, 64'h0000_5678_0000_1234);
      end
      if (k == 2) check_eq("sat_k2", stat_fwd_s, 64'd2);
      if (k == 8) check_eq("sat_k8", stat_fwd_s, 64'd14);
      if (k == 9) check_eq("sat_k9", stat_fwd_s, 64'd15);
    end
    tick();
    clr_inputs();
    @(negedge clk);
    check_eq("sat_final", stat_fwd_s, 64'd15);
    check_eq("wide_final", stat_fwd1, 64'd40);
    check_eq("sat_no_stall", stat_stall_s, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bypass_forward_ctrl.md
# bypass_forward_ctrl

Parametrised forwarding and load-use interlock unit for the five-stage pipeline, placed at the ID/EX boundary. It compares each ID-stage source register against the EX, MEM and WB destinations, selects the youngest valid producer per source port and drives the forwarded operands. It stalls ID for a configurable number of cycles on a load-use hazard and keeps saturating hazard-statistics counters.

## Interface
- DATA_W, 32: operand width.
- ADDR_W, 5: register address width.
- NUM_SRC, 2: number of ID source ports (rs, rt, ...).
- LOAD_LAT, 1: stall cycles on load-use; legal 1..3.
- CNT_W, 32: statistics counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src_addr  in  NUM_SRC*ADDR_W  source register addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- id_src_used  in  NUM_SRC  port i actually reads its register.
- id_rf_data  in  NUM_SRC*DATA_W  register-file read data.
- ex_wr_en, ex_is_load  in  1 each  EX writes a register / EX holds a load.
- ex_wr_addr  in  ADDR_W;  ex_alu_res  in  DATA_W.
- mem_wr_en  in  1;  mem_wr_addr  in  ADDR_W;  mem_wr_data  in  DATA_W  EXE/MEM result, or load data.
- wb_wr_en  in  1;  wb_wr_addr  in  ADDR_W;  wb_wr_data  in  DATA_W.
- flush  in  1  pipeline flush (branch/exception).
- fwd_data  out  NUM_SRC*DATA_W  forwarded operands.
- fwd_sel  out  NUM_SRC*4  per-port one-hot selector: bit0 RF, bit1 EX, bit2 MEM, bit3 WB.
- stall  out  1  hold PC/IF/ID and insert an EX bubble.
- stat_stall_cyc  out  CNT_W  total cycles with stall=1.
- stat_fwd_evt  out  CNT_W  count of ports forwarded from a non-RF source on unstalled, valid cycles.

## Operation
- Per port i, match_X = X_wr_en & (X_wr_addr == src_i) & (src_i != 0) & id_src_used[i].
- Priority is EX > MEM > WB > RF. fwd_sel is always exactly one-hot and is never 0. Register 0 and unused ports always select RF.
- EX forwards ex_alu_res only when ex_is_load=0. A matching EX load does not forward. That port falls through to MEM/WB/RF, and a hazard is raised.
- hazard = id_valid & ~flush & any port with match_EX & ex_is_load.
- FSM states:
  - IDLE: stall = hazard. On hazard with LOAD_LAT>1, load cnt = LOAD_LAT-1 and go to HOLD.
  - HOLD: stall=1. cnt decrements each cycle; return to IDLE on the cycle cnt reaches 1→0 (HOLD lasts LOAD_LAT-1 cycles).
  - flush in any state: stall=0 that cycle, next state IDLE, cnt=0.
- A new hazard in the same cycle HOLD exits is evaluated in IDLE on the next cycle. No hazard evaluation occurs inside HOLD.
- Counters saturate at all-ones and do not wrap. stat_fwd_evt adds the number of ports forwarded that cycle (0..NUM_SRC).
- fwd_data and fwd_sel are combinational and stay valid during stall. The consumer ignores them while stall=1.

## Timing
- fwd_data/fwd_sel: zero latency, combinational from inputs.
- stall: combinational in IDLE, registered-state-driven in HOLD. Total stall for one load-use = LOAD_LAT cycles.
- Reset (synchronous, active-high) gives: state IDLE, cnt 0, stall 0 (absent a combinational hazard while rst=1), stat_stall_cyc 0, stat_fwd_evt 0.
- rst has priority over flush. A reset mid-HOLD clears stall from the next cycle.
- Counters update at the clock edge after the counted cycle. They read 0 in the first cycle after reset.

## Test plan
- Priority: src0=5 with EX, MEM and WB all writing r5 (ex_alu_res=0x11, mem=0x22, wb=0x33), no load -> fwd_sel[3:0]=0010, fwd_data0=0x11. Drop ex_wr_en -> 0100, 0x22. Drop mem_wr_en -> 1000, 0x33.
- Zero register: src0=0, EX writes r0 with 0xDEAD -> fwd_sel=0001, fwd_data0=id_rf_data0. stat_fwd_evt unchanged.
- Load-use, LOAD_LAT=1: EX load to r7, src1=7 used -> stall=1 for exactly 1 cycle and stat_stall_cyc=1. Next cycle load is in MEM with 0xCAFE -> fwd_sel1=0100, fwd_data1=0xCAFE, stall=0.
- LOAD_LAT=3: same hazard -> stall high for exactly 3 consecutive cycles, then low. stat_stall_cyc=3.
- Flush/reset mid-stall (LOAD_LAT=3): flush in the 2nd stall cycle -> stall=0 that cycle, IDLE next. Repeat with rst -> stall=0 from the next cycle, counters=0.
- Saturation (CNT_W=4): 20 cycles of both ports forwarding -> stat_fwd_evt holds 15, no wrap.
